fifo_arb_tx: RTL and testbench

- Transmit-side counterpart of the RX splitter.
- Drains two client read-FIFOs (c1, c2) and merges them into one output FIFO as framed packets: a header word carrying channel select and payload count, followed by that many payload words.
- The RX arbiter at the far end uses SELMASK/CNTMASK to demultiplex the packets.

---
 rtl/fifo_arb_tx.sv | 141 ++++++++++++++
 tb/tb_fifo_arb_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arb_tx.sv
// fifo_arb_tx: drains two client read-FIFOs into one output FIFO as framed packets
// (header = channel bit | payload count, then payload). Define FIFO_ARB_TX_PRIO_EN for strict c1 priority.
module fifo_arb_tx #(
    parameter int                DWIDTH   = 8,
    parameter logic [DWIDTH-1:0] SELMASK  = 8'h80,
    parameter logic [DWIDTH-1:0] CNTMASK  = 8'h70,
    parameter int                CNTSHIFT = 4
) (
    input  logic              CLK,
    input  logic              RESETn,
    output logic              c1_rden,
    input  logic              c1_rdempty,
    input  logic [DWIDTH-1:0] c1_rddata,
    output logic              c2_rden,
    input  logic              c2_rdempty,
    input  logic [DWIDTH-1:0] c2_rddata,
    output logic              fifo_wren,
    input  logic              fifo_wrfull,
    output logic [DWIDTH-1:0] fifo_wrdata
);
    localparam int CNTMAX = int'(CNTMASK >> CNTSHIFT);
    localparam int CW     = $clog2(CNTMAX + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HDR, PAY} state_t;

    state_t            state_q;
    logic              sel_q;
    logic              pend_q;
    logic [CW-1:0]     issued_q;
    logic [CW-1:0]     captured_q;
    logic [CW-1:0]     idx_q;
    logic [DWIDTH-1:0] data_q [CNTMAX];
`ifndef FIFO_ARB_TX_PRIO_EN
    logic              ptr_q;
`endif

    logic              sel_empty;
    logic              rd_en;
    logic              wr_en;
    logic              last_pay;
    logic [DWIDTH-1:0] sel_data;
    logic [DWIDTH-1:0] hdr_word;

    always_comb begin
        sel_empty = sel_q ? c2_rdempty : c1_rdempty;
        sel_data  = sel_q ? c2_rddata  : c1_rddata;
        // Strobes are gated by RESETn so nothing is popped or written during a reset cycle.
        rd_en     = RESETn && (state_q == COLLECT) && !sel_empty && (issued_q < CW'(CNTMAX));
        wr_en     = RESETn && ((state_q == HDR) || (state_q == PAY)) && !fifo_wrfull;
        last_pay  = (idx_q + 1'b1) == captured_q;
        hdr_word  = (sel_q ? SELMASK : '0) | ((DWIDTH'(captured_q) << CNTSHIFT) & CNTMASK);
        fifo_wrdata = '0;
        if (state_q == HDR) begin
            fifo_wrdata = hdr_word;
        end else if (state_q == PAY) begin
            fifo_wrdata = data_q[idx_q];
        end
    end

    assign c1_rden   = rd_en & ~sel_q;
    assign c2_rden   = rd_en &  sel_q;
    assign fifo_wren = wr_en;

    always_ff @(posedge CLK) begin
        if ((state_q == COLLECT) && pend_q) begin
            data_q[captured_q] <= sel_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            pend_q     <= 1'b0;
            issued_q   <= '0;
            captured_q <= '0;
            idx_q      <= '0;
`ifndef FIFO_ARB_TX_PRIO_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    pend_q     <= 1'b0;
                    issued_q   <= '0;
                    captured_q <= '0;
                    idx_q      <= '0;
`ifdef FIFO_ARB_TX_PRIO_EN
                    if (!c1_rdempty) begin
                        sel_q   <= 1'b0;
                        state_q <= COLLECT;
                    end else if (!c2_rdempty) begin
                        sel_q   <= 1'b1;
                        state_q <= COLLECT;
                    end
`else
                    if (ptr_q ? !c2_rdempty : !c1_rdempty) begin
                        sel_q   <= ptr_q;
                        state_q <= COLLECT;
                    end else if (ptr_q ? !c1_rdempty : !c2_rdempty) begin
                        sel_q   <= ~ptr_q;
                        state_q <= COLLECT;
                    end
`endif
                end
                COLLECT: begin
                    pend_q <= rd_en;
                    if (rd_en) begin
                        issued_q <= issued_q + 1'b1;
                    end
                    if (pend_q) begin
                        captured_q <= captured_q + 1'b1;
                    end
                    // Last capture lands on this edge; an empty start falls back to IDLE.
                    if (!rd_en) begin
                        state_q <= (pend_q || (captured_q != '0)) ? HDR : IDLE;
                    end
                end
                HDR: begin
                    idx_q <= '0;
                    if (!fifo_wrfull) begin
                        state_q <= PAY;
                    end
                end
                PAY: begin
                    if (!fifo_wrfull) begin
                        if (last_pay) begin
                            state_q <= IDLE;
`ifndef FIFO_ARB_TX_PRIO_EN
                            ptr_q   <= ~sel_q;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_arb_tx.sv
// Self-checking bench for fifo_arb_tx: client FIFOs as queues, packet-level reference model.
module tb_fifo_arb_tx;
    logic       CLK = 1'b0;
    logic       RESETn;
    logic       c1_rden, c1_rdempty;
    logic [7:0] c1_rddata;
    logic       c2_rden, c2_rdempty;
    logic [7:0] c2_rddata;
    logic       fifo_wren, fifo_wrfull;
    logic [7:0] fifo_wrdata;

    fifo_arb_tx dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .c1_rden    (c1_rden),
        .c1_rdempty (c1_rdempty),
        .c1_rddata  (c1_rddata),
        .c2_rden    (c2_rden),
        .c2_rdempty (c2_rdempty),
        .c2_rddata  (c2_rddata),
        .fifo_wren  (fifo_wren),
        .fifo_wrfull(fifo_wrfull),
        .fifo_wrdata(fifo_wrdata)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         pops1    = 0;
    logic [7:0] c1q[$], c2q[$];        // client FIFO contents
    logic [7:0] mq1[$], mq2[$];        // model view of unconsumed client words
    logic [7:0] exp_pay[$];
    logic [7:0] wlog[$];
    int         wcyc[$];
    bit         in_pkt   = 0;
    bit         mptr     = 0;
    bit         cur_ch   = 0;
    bit         bp_en    = 0;
    bit         chk_zero = 0;
    logic [7:0] rr_exp [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] wl(input int i);
        if (i < wlog.size()) return wlog[i];
        return 8'hxx;
    endfunction

    // Packet-level model: decide channel and count when a header appears.
    task automatic model_write(input logic [7:0] d);
        int         n;
        bit         ch;
        logic [7:0] hdr;
        if (!in_pkt) begin
            if (mq1.size() == 0 && mq2.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_write: got %0h required no write (cycle %0d)", d, cyc);
            end else begin
`ifdef FIFO_ARB_TX_PRIO_EN
                ch = (mq1.size() == 0);
`else
                if (!mptr) ch = (mq1.size() == 0);
                else       ch = (mq2.size() != 0);
`endif
                n = ch ? mq2.size() : mq1.size();
                if (n > 7) n = 7;
                for (int i = 0; i < n; i++) begin
                    if (ch) exp_pay.push_back(mq2.pop_front());
                    else    exp_pay.push_back(mq1.pop_front());
                end
                hdr = (ch ? 8'h80 : 8'h00) | 8'(n << 4);
                check("header", {24'h0, d}, {24'h0, hdr});
                in_pkt = 1;
                cur_ch = ch;
            end
        end else begin
            check("payload", {24'h0, d}, {24'h0, exp_pay.pop_front()});
            if (exp_pay.size() == 0) begin
                in_pkt = 0;
                mptr   = !cur_ch;
            end
        end
    endtask

    task automatic tick();
        bit p1, p2;
        @(negedge CLK);
        p1 = c1_rden;
        p2 = c2_rden;
        if (chk_zero) begin
            check("zero_c1_rden", {31'h0, c1_rden}, 32'h0);
            check("zero_c2_rden", {31'h0, c2_rden}, 32'h0);
            check("zero_fifo_wren", {31'h0, fifo_wren}, 32'h0);
            check("zero_fifo_wrdata", {24'h0, fifo_wrdata}, 32'h0);
            chk_zero = 0;
        end
        check("rden_exclusive", {31'h0, c1_rden & c2_rden}, 32'h0);
        check("c1_rden_when_empty", {31'h0, c1_rden & c1_rdempty}, 32'h0);
        check("c2_rden_when_empty", {31'h0, c2_rden & c2_rdempty}, 32'h0);
        check("wren_while_full", {31'h0, fifo_wren & fifo_wrfull}, 32'h0);
        if (fifo_wren === 1'b1) begin
            wlog.push_back(fifo_wrdata);
            wcyc.push_back(cyc);
            model_write(fifo_wrdata);
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (p1 && c1q.size() > 0) begin
            c1_rddata = c1q.pop_front();
            pops1++;
        end
        if (p2 && c2q.size() > 0) c2_rddata = c2q.pop_front();
        c1_rdempty  = (c1q.size() == 0);
        c2_rdempty  = (c2q.size() == 0);
        fifo_wrfull = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic push(input bit ch, input logic [7:0] w);
        if (!ch) begin
            c1q.push_back(w);
            mq1.push_back(w);
            c1_rdempty = 1'b0;
        end else begin
            c2q.push_back(w);
            mq2.push_back(w);
            c2_rdempty = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((mq1.size() != 0 || mq2.size() != 0 || in_pkt) && k < 3000) begin
            tick();
            k++;
        end
        check("drain_done", {31'h0, k < 3000}, 32'h1);
        repeat (12) tick();
    endtask

    initial begin
        int t0, rem, n1, n2;
        logic [7:0] hdr_rst;
`ifdef FIFO_ARB_TX_PRIO_EN
        rr_exp[0] = 8'h70; rr_exp[1] = 8'h70; rr_exp[2] = 8'hF0; rr_exp[3] = 8'hF0;
`else
        rr_exp[0] = 8'h70; rr_exp[1] = 8'hF0; rr_exp[2] = 8'h70; rr_exp[3] = 8'hF0;
`endif
        RESETn      = 1'b0;
        fifo_wrfull = 1'b0;
        c1_rdempty  = 1'b1;
        c2_rdempty  = 1'b1;
        c1_rddata   = 8'h00;
        c2_rddata   = 8'h00;
        tick();
        tick();
        RESETn   = 1'b1;
        chk_zero = 1;
        repeat (3) tick();

        // Single burst with latency pin
        wlog.delete(); wcyc.delete();
        t0 = cyc;
        push(0, 8'hA1); push(0, 8'hB2); push(0, 8'hC3);
        drain();
        check("burst_len", wlog.size(), 4);
        check("burst_w0", {24'h0, wl(0)}, 32'h30);
        check("burst_w1", {24'h0, wl(1)}, 32'hA1);
        check("burst_w2", {24'h0, wl(2)}, 32'hB2);
        check("burst_w3", {24'h0, wl(3)}, 32'hC3);
        if (wcyc.size() == 4) begin
            check("burst_hdr_latency", wcyc[0] - t0, 5);
            check("burst_last_latency", wcyc[3] - t0, 8);
        end

        // Max and split
        wlog.delete(); wcyc.delete();
        for (int i = 0; i < 10; i++) push(1, 8'($urandom));
        drain();
        check("split_len", wlog.size(), 12);
        check("split_hdr0", {24'h0, wl(0)}, 32'hF0);
        check("split_hdr1", {24'h0, wl(8)}, 32'hB0);

        // Both channels loaded
        wlog.delete(); wcyc.delete();
        for (int i = 0; i < 14; i++) begin
            push(0, 8'($urandom));
            push(1, 8'($urandom));
        end
        drain();
        check("rr_len", wlog.size(), 32);
        for (int i = 0; i < 4; i++) check("rr_hdr", {24'h0, wl(8 * i)}, {24'h0, rr_exp[i]});

        // Backpressure
        wlog.delete(); wcyc.delete();
        bp_en = 1;
        for (int i = 0; i < 20; i++) push(0, 8'($urandom));
        for (int i = 0; i < 9; i++)  push(1, 8'($urandom));
        drain();
        bp_en = 0;
        check("bp_len", wlog.size(), 34);

        // Reset mid-collect
        wlog.delete(); wcyc.delete();
        pops1 = 0;
        for (int i = 0; i < 7; i++) push(0, 8'($urandom));
        for (int k = 0; k < 100 && pops1 < 3; k++) tick();
        check("collect_reached", {31'h0, pops1 >= 3}, 32'h1);
        RESETn = 1'b0;
        tick();
        RESETn = 1'b1;
        mq1 = c1q;
        mq2 = c2q;
        exp_pay.delete();
        in_pkt   = 0;
        mptr     = 0;
        chk_zero = 1;
        hdr_rst  = 8'(c1q.size() << 4);
        drain();
        check("rst_len", wlog.size(), 32'(hdr_rst >> 4) + 1);
        check("rst_hdr", {24'h0, wl(0)}, {24'h0, hdr_rst});

        // Random soak
        rem = 247;
        while (rem > 0) begin
            n1 = int'($urandom_range(0, (rem < 20) ? rem : 20));
            rem -= n1;
            n2 = int'($urandom_range(0, (rem < 20) ? rem : 20));
            rem -= n2;
            if (n1 + n2 == 0) begin
                n1 = 1;
                rem -= 1;
            end
            bp_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < n1; i++) push(0, 8'($urandom));
            for (int i = 0; i < n2; i++) push(1, 8'($urandom));
            drain();
            bp_en = 0;
        end
        check("soak_model_empty", {31'h0, in_pkt}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
